// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential word fetch over req/gnt/rvalid, {instr,pc} FIFO to the core,
// redirect flush with in-flight drop accounting. Optional IFETCH_MISALIGN_TRAP_EN halts on misaligned redirects.
module instr_fetch #(
  parameter int          DEPTH     = 4,
  parameter logic [13:0] BOOT_ADDR = 14'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [13:0] instr_addr_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [13:0] redirect_addr_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [13:0] pc_o,
  input  logic        ready_i,
  output logic        misalign_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = AW + 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [13:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d, live_q, live_d;
  logic [DW-1:0] drop_q, drop_d, owed;
  logic [13:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW:0]   credit;
  logic          halt, pop, accept, flush, drop_hit, kept, push, do_pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic halt_q, halt_d;
  always_comb begin
    halt_d = halt_q;
    if (rst_i)           halt_d = 1'b0;
    else if (redirect_i) halt_d = |redirect_addr_i[1:0];
  end
  always_ff @(posedge clk_i) halt_q <= halt_d;
  assign halt       = halt_q;
  assign misalign_o = halt_q;
`else
  assign halt       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign valid_o = (cnt_q != '0);
  assign pop     = valid_o && ready_i;
  // Outstanding slots include live fetches so a response can never find the FIFO full.
  assign credit  = {1'b0, cnt_q} + {1'b0, live_q} - (CW+1)'(pop);
  assign instr_req_o  = !rst_i && !redirect_i && !halt && (credit < (CW+1)'(DEPTH));
  assign instr_addr_o = fetch_pc_q;
  assign accept   = instr_req_o && instr_gnt_i;
  assign flush    = rst_i || redirect_i;
  assign drop_hit = instr_rvalid_i && (drop_q != '0);
  assign kept     = instr_rvalid_i && !drop_hit;
  assign push     = kept && !flush && !halt;
  assign do_pop   = pop && !flush;
  assign owed     = drop_q + DW'(live_q);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (flush) begin
      fetch_pc_d = rst_i ? BOOT_ADDR : (redirect_addr_i & 14'h3FFC);
      resp_pc_d  = fetch_pc_d;
      live_d     = '0;
      // Everything still owed by memory becomes a drop; one may be arriving right now.
      drop_d     = (instr_rvalid_i && owed != '0) ? owed - DW'(1) : owed;
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 14'd4;
      if (push)   resp_pc_d  = resp_pc_q + 14'd4;
      live_d = live_q + CW'(accept) - CW'(kept);
      if (drop_hit) drop_d = drop_q - DW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(do_pop);
      wr_d  = wr_q + AW'(push);
      rd_d  = rd_q + AW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      live_q     <= '0;
      drop_q     <= drop_d;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= '{instr: instr_rdata_i, pc: resp_pc_q};
  end

  assign instr_o = mem_q[rd_q].instr;
  assign pc_o    = mem_q[rd_q].pc;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && cnt_q == CW'(DEPTH)));
endmodule
